// File: rtl/mem_dump_pkg.sv
// Shared types and helpers for the data-memory dump engine.
package mem_dump_pkg;

    // Width of one transmitted unit on the UART byte interface.
    localparam int unsigned BYTE_W = 8;

    // Dump sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } dump_state_t;

    // Number of bytes that make up one memory word.
    function automatic int unsigned bytes_per_word(input int unsigned bus_size);
        return bus_size / BYTE_W;
    endfunction

endpackage

// File: rtl/mem_dump_serializer.sv
// Word-to-byte serializer: holds one snapshotted word and offers it MSB-first
// on a valid/ready byte interface. Reports when the last byte has gone out.
module mem_dump_serializer
    import mem_dump_pkg::*;
#(
    parameter int IO_BUS_SIZE = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_load,
    input  logic [IO_BUS_SIZE-1:0] i_word,
    input  logic                   i_tx_ready,
    output logic [BYTE_W-1:0]      o_tx_data,
    output logic                   o_tx_valid,
    output logic                   o_last_xfer
);

    localparam int unsigned BYTES = bytes_per_word(IO_BUS_SIZE);
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    logic [IO_BUS_SIZE-1:0] shift_reg;
    logic [CNT_W-1:0]       byte_cnt;
    logic                   valid_q;
    logic                   xfer;

    assign xfer        = valid_q & i_tx_ready;
    assign o_last_xfer = xfer & (byte_cnt == LAST_BYTE);

    // Snapshot a word on load, then shift one byte out per accepted transfer.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
            valid_q   <= 1'b0;
        end else if (i_load) begin
            shift_reg <= i_word;
            byte_cnt  <= '0;
            valid_q   <= 1'b1;
        end else if (xfer) begin
            if (byte_cnt == LAST_BYTE) begin
                // Last byte accepted: stop offering until the next word is loaded.
                valid_q <= 1'b0;
            end else begin
                shift_reg <= shift_reg << BYTE_W;
                byte_cnt  <= byte_cnt + 1'b1;
            end
        end
    end

    assign o_tx_data  = shift_reg[IO_BUS_SIZE-1 -: BYTE_W];
    assign o_tx_valid = valid_q;

endmodule

// File: rtl/mem_dump_tx.sv
// Debug read-out engine: on request, walks the data-memory debug image word by
// word (ascending) and streams each word MSB-first over a byte valid/ready port.
module mem_dump_tx
    import mem_dump_pkg::*;
#(
    parameter int IO_BUS_SIZE   = 32,
    parameter int MEM_ADDR_SIZE = 5
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic                                      i_start,
    input  logic [(2**MEM_ADDR_SIZE)*IO_BUS_SIZE-1:0] i_bus_debug,
    input  logic                                      i_tx_ready,
    output logic [7:0]                                o_tx_data,
    output logic                                      o_tx_valid,
    output logic                                      o_busy,
    output logic                                      o_done,
    output logic [MEM_ADDR_SIZE-1:0]                  o_word_addr
);

    localparam int unsigned WORDS = 1 << MEM_ADDR_SIZE;
    localparam int unsigned IMG_W = WORDS * IO_BUS_SIZE;
    localparam int unsigned SEL_W = $clog2(IMG_W);
    localparam logic [MEM_ADDR_SIZE-1:0] LAST_WORD = '1;

    dump_state_t              state_q;
    dump_state_t              state_d;
    logic [MEM_ADDR_SIZE-1:0] word_idx;
    logic                     load;
    logic                     last_xfer;
    logic [SEL_W-1:0]         sel_base;
    logic [IO_BUS_SIZE-1:0]   word_sel;

    // Bit offset of the current word inside the flat memory image.
    assign sel_base = SEL_W'(word_idx) * SEL_W'(IO_BUS_SIZE);
    assign word_sel = i_bus_debug[sel_base +: IO_BUS_SIZE];

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; the serializer load strobe is asserted only in LOAD.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (last_xfer) begin
                    state_d = (word_idx == LAST_WORD) ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Word index: cleared on an accepted start, advanced after each word's last byte.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            word_idx <= '0;
        end else if (state_q == ST_IDLE && i_start) begin
            word_idx <= '0;
        end else if (state_q == ST_SEND && last_xfer && word_idx != LAST_WORD) begin
            word_idx <= word_idx + 1'b1;
        end
    end

    mem_dump_serializer #(
        .IO_BUS_SIZE(IO_BUS_SIZE)
    ) u_serializer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (load),
        .i_word     (word_sel),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_last_xfer(last_xfer)
    );

    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign o_word_addr = word_idx;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Scoreboard bench for mem_dump_tx: expected byte streams are derived from the
// memory image and pushed at start; a monitor pops and compares on each transfer.
module tb_mem_dump_tx;

    localparam int W     = 32;
    localparam int A     = 5;
    localparam int WORDS = 1 << A;
    localparam int BYTES = W / 8;
    localparam int NB    = WORDS * BYTES;

    logic               clk = 1'b0;
    logic               i_reset;
    logic               i_start;
    logic               i_tx_ready;
    logic [WORDS*W-1:0] bus;
    logic [7:0]         o_tx_data;
    logic               o_tx_valid;
    logic               o_busy;
    logic               o_done;
    logic [A-1:0]       o_word_addr;

    logic [W-1:0] mem_img [WORDS];
    logic [7:0]   sb_q [$];

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    bit rand_ready   = 1'b0;
    bit ready_manual = 1'b0;

    mem_dump_tx #(
        .IO_BUS_SIZE  (W),
        .MEM_ADDR_SIZE(A)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_bus_debug(bus),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_word_addr(o_word_addr)
    );

    always #5 clk = ~clk;

    // Flatten the memory image onto the debug bus: word k at bits k*W +: W.
    always_comb begin
        bus = '0;
        for (int k = 0; k < WORDS; k++) bus[k*W +: W] = mem_img[k];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference stream: ascending words, most significant byte first.
    task automatic push_expected();
        for (int w = 0; w < WORDS; w++)
            for (int b = 0; b < BYTES; b++)
                sb_q.push_back(8'(mem_img[w] >> (8 * (BYTES - 1 - b))));
    endtask

    // Observe the byte port between edges; a transfer is valid&ready at the next edge.
    task automatic monitor();
        bit         stall_prev = 1'b0;
        logic [7:0] stall_data = '0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!i_reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", 32'(o_tx_valid), 32'd1);
                    chk("hold_data", 32'(o_tx_data), 32'(stall_data));
                end
                if (o_done) done_cnt++;
                if (o_tx_valid && i_tx_ready) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte: got %0h expected none", o_tx_data);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("byte%0d", xfer_cnt), 32'(o_tx_data), 32'(e));
                    end
                    xfer_cnt++;
                end
                stall_prev = o_tx_valid && !i_tx_ready;
                stall_data = o_tx_data;
            end
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            if (!ready_manual) i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic start_dump();
        done_cnt = 0;
        xfer_cnt = 0;
        i_start  = 1'b1;
        step();
        i_start  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!o_done && n < budget) begin
            step();
            n++;
        end
        if (!o_done) timeout(name);
    endtask

    task automatic end_dump(input string name);
        repeat (4) step();
        chk({name, "_count"}, 32'(xfer_cnt), 32'(NB));
        chk({name, "_done"}, 32'(done_cnt), 32'd1);
        chk({name, "_busy"}, 32'(o_busy), 32'd0);
        chk({name, "_left"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_valid"}, 32'(o_tx_valid), 32'd0);
        chk({name, "_data"}, 32'(o_tx_data), 32'd0);
        chk({name, "_busy"}, 32'(o_busy), 32'd0);
        chk({name, "_done"}, 32'(o_done), 32'd0);
        chk({name, "_addr"}, 32'(o_word_addr), 32'd0);
    endtask

    task automatic basic_image();
        for (int k = 0; k < WORDS; k++) mem_img[k] = '0;
        mem_img[0] = 32'hDEADBEEF;
        mem_img[1] = 32'h01234567;
    endtask

    initial begin
        int n;
        i_reset    = 1'b0;
        i_start    = 1'b0;
        i_tx_ready = 1'b1;
        basic_image();
        fork
            monitor();
            ready_drv();
        join_none

        // Reset state
        repeat (3) step();
        check_idle_outputs("reset");
        i_reset = 1'b1;
        step();

        // Basic order
        push_expected();
        start_dump();
        wait_done("basic", 1000);
        end_dump("basic");

        // Backpressure on byte 0xAD
        push_expected();
        start_dump();
        n = 0;
        while (!(o_tx_valid && o_tx_data == 8'hAD) && n < 100) begin
            step();
            n++;
        end
        if (!(o_tx_valid && o_tx_data == 8'hAD)) timeout("bp_find");
        ready_manual = 1'b1;
        i_tx_ready   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_valid", 32'(o_tx_valid), 32'd1);
            chk("bp_data", 32'(o_tx_data), 32'hAD);
        end
        i_tx_ready   = 1'b1;
        ready_manual = 1'b0;
        wait_done("bp", 1000);
        end_dump("bp");

        // Start while busy (word 3) and during DONE
        push_expected();
        start_dump();
        n = 0;
        while (!(o_word_addr == 3 && o_tx_valid) && n < 200) begin
            step();
            n++;
        end
        if (!(o_word_addr == 3 && o_tx_valid)) timeout("busy_find");
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        wait_done("busy", 1000);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        end_dump("busy");

        // Reset during word 10 byte 2
        push_expected();
        start_dump();
        n = 0;
        while (xfer_cnt != 10 * BYTES + 2 && n < 500) begin
            step();
            n++;
        end
        if (xfer_cnt != 10 * BYTES + 2) timeout("rst_find");
        chk("rst_addr", 32'(o_word_addr), 32'd10);
        i_reset = 1'b0;
        step();
        check_idle_outputs("midreset");
        i_reset = 1'b1;
        sb_q.delete();
        step();
        push_expected();
        start_dump();
        wait_done("rst_again", 1000);
        end_dump("rst_again");

        // Snapshot boundary: word5 changes after its LOAD, word6 before its LOAD
        basic_image();
        mem_img[5] = 32'h11111111;
        mem_img[6] = 32'h55555555;
        push_expected();
        for (int b = 0; b < BYTES; b++) sb_q[6 * BYTES + b] = 8'h66;
        start_dump();
        n = 0;
        while (!(o_word_addr == 5 && o_busy && !o_tx_valid) && n < 200) begin
            step();
            n++;
        end
        if (!(o_word_addr == 5 && o_busy && !o_tx_valid)) timeout("snap_find");
        step();
        mem_img[5] = 32'h22222222;
        mem_img[6] = 32'h66666666;
        wait_done("snap", 1000);
        end_dump("snap");

        // Random stress
        rand_ready = 1'b1;
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < WORDS; k++) mem_img[k] = $urandom;
            push_expected();
            start_dump();
            wait_done("rand", 3000);
            end_dump("rand");
        end
        rand_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
